// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle sequencer: opcodes, ALU codes, FSM states
// and the instruction classes produced by the opcode decoder.
package mc_ctrl_pkg;

  localparam logic [3:0] OP_JMP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_LI  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_INV = 4'h8;
  localparam logic [3:0] OP_LSL = 4'h9;
  localparam logic [3:0] OP_LSR = 4'hA;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_SLT = 4'hF;

  localparam logic [3:0] ALU_PASSB = 4'b0000;
  localparam logic [3:0] ALU_AND   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_INV   = 4'b0101;
  localparam logic [3:0] ALU_LSL   = 4'b0110;
  localparam logic [3:0] ALU_LSR   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;

  // ST_ERR is only reachable when the memory-wait timeout is built in
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_JMP = 3'd0,
    CL_LD  = 3'd1,
    CL_ST  = 3'd2,
    CL_LI  = 3'd3,
    CL_ALU = 3'd4,
    CL_BEQ = 3'd5,
    CL_BNE = 3'd6,
    CL_ILL = 3'd7
  } opclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the static datapath
// selects (ALU op, B-operand source, write-back destination/source).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  output opclass_t         op_class,
  output logic [3:0]       alu_control,
  output logic             alu_b_sel,
  output logic             reg_write_dst,
  output logic             mem_to_reg
);

  always_comb begin
    op_class      = CL_ILL;
    alu_control   = ALU_PASSB;
    alu_b_sel     = 1'b0;
    reg_write_dst = 1'b0;
    mem_to_reg    = 1'b0;
    case (opcode)
      OPC_W'(OP_JMP): op_class = CL_JMP;
      OPC_W'(OP_LD): begin
        op_class      = CL_LD;
        alu_control   = ALU_ADD;
        reg_write_dst = 1'b1;
        mem_to_reg    = 1'b1;
      end
      OPC_W'(OP_ST): begin
        op_class    = CL_ST;
        alu_control = ALU_ADD;
      end
      OPC_W'(OP_LI): begin
        op_class      = CL_LI;
        alu_control   = ALU_ADD;
        reg_write_dst = 1'b1;
      end
      OPC_W'(OP_ADD): begin op_class = CL_ALU; alu_control = ALU_ADD; alu_b_sel = 1'b1; end
      OPC_W'(OP_SUB): begin op_class = CL_ALU; alu_control = ALU_SUB; alu_b_sel = 1'b1; end
      OPC_W'(OP_AND): begin op_class = CL_ALU; alu_control = ALU_AND; alu_b_sel = 1'b1; end
      OPC_W'(OP_OR):  begin op_class = CL_ALU; alu_control = ALU_OR;  alu_b_sel = 1'b1; end
      OPC_W'(OP_INV): begin op_class = CL_ALU; alu_control = ALU_INV; alu_b_sel = 1'b1; end
      OPC_W'(OP_LSL): begin op_class = CL_ALU; alu_control = ALU_LSL; alu_b_sel = 1'b1; end
      OPC_W'(OP_LSR): begin op_class = CL_ALU; alu_control = ALU_LSR; alu_b_sel = 1'b1; end
      OPC_W'(OP_SLT): begin op_class = CL_ALU; alu_control = ALU_SLT; alu_b_sel = 1'b1; end
      // Branches compare two registers by subtraction
      OPC_W'(OP_BEQ): begin op_class = CL_BEQ; alu_control = ALU_SUB; alu_b_sel = 1'b1; end
      OPC_W'(OP_BNE): begin op_class = CL_BNE; alu_control = ALU_SUB; alu_b_sel = 1'b1; end
      default:        op_class = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack memory handshakes.
// Define MC_CTRL_TIMEOUT_EN to add the memory-wait timeout and bus_err reporting.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int OPC_W       = 4,
  parameter int FLAG_W      = 8,
  parameter int ZERO_IDX    = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic [FLAG_W-1:0]  alu_flags,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic               imem_req,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [3:0]         alu_control,
  output logic               alu_b_sel,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               reg_write,
  output logic               reg_write_dst,
  output logic               mem_to_reg,
  output logic               illegal_op,
  output logic               bus_err
);

  state_t           state;
  logic [OPC_W-1:0] opc_q;
  logic [OPC_W-1:0] cur_opc;
  opclass_t         op_class;
  logic [3:0]       dec_alu;
  logic             dec_b_sel;
  logic             dec_rwd;
  logic             dec_m2r;
  logic             zero;
  logic             timed_out;
  logic             unused_ok;

  assign zero      = alu_flags[ZERO_IDX];
  assign unused_ok = ^{instr[INSTR_W-OPC_W-1:0], alu_flags};

  // The IR is valid from DECODE on; the opcode is held locally after that
  assign cur_opc = (state == ST_DECODE) ? instr[INSTR_W-1 -: OPC_W] : opc_q;

  mc_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode        (cur_opc),
    .op_class      (op_class),
    .alu_control   (dec_alu),
    .alu_b_sel     (dec_b_sel),
    .reg_write_dst (dec_rwd),
    .mem_to_reg    (dec_m2r)
  );

`ifdef MC_CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign timed_out = (wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      opc_q <= '0;
`ifdef MC_CTRL_TIMEOUT_EN
      wait_cnt <= 8'd0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack)       state <= ST_DECODE;
          else if (timed_out) state <= ST_ERR;
        end
        ST_DECODE: begin
          opc_q <= instr[INSTR_W-1 -: OPC_W];
          if (op_class == CL_JMP || op_class == CL_ILL) state <= ST_FETCH;
          else                                          state <= ST_EXEC;
        end
        ST_EXEC: begin
          case (op_class)
            CL_LD, CL_ST:   state <= ST_MEM;
            CL_LI, CL_ALU:  state <= ST_WB;
            default:        state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack)       state <= (op_class == CL_LD) ? ST_WB : ST_FETCH;
          else if (timed_out) state <= ST_ERR;
        end
        default: state <= ST_FETCH;
      endcase
`ifdef MC_CTRL_TIMEOUT_EN
      // Counts un-acked request cycles; any state change restarts it at zero
      if ((state == ST_FETCH && !imem_ack) || (state == ST_MEM && !dmem_ack))
        wait_cnt <= timed_out ? 8'd0 : wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
`endif
    end
  end

  // Reset forces every strobe low even though the state already reads FETCH
  always_comb begin
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    alu_control   = ALU_PASSB;
    alu_b_sel     = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    reg_write     = 1'b0;
    reg_write_dst = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;
    bus_err       = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ack;
          pc_inc   = imem_ack;
        end
        ST_DECODE: begin
          pc_load    = (op_class == CL_JMP);
          illegal_op = (op_class == CL_ILL);
        end
        ST_EXEC: begin
          alu_control = dec_alu;
          alu_b_sel   = dec_b_sel;
          if (op_class == CL_BEQ) pc_load = zero;
          if (op_class == CL_BNE) pc_load = !zero;
        end
        ST_MEM: begin
          dmem_req    = 1'b1;
          dmem_we     = (op_class == CL_ST);
          alu_control = dec_alu;
          alu_b_sel   = dec_b_sel;
        end
        ST_WB: begin
          reg_write     = 1'b1;
          reg_write_dst = dec_rwd;
          mem_to_reg    = dec_m2r;
        end
`ifdef MC_CTRL_TIMEOUT_EN
        ST_ERR: bus_err = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle vector table with a
// scoreboard queue, plus hand-driven reset and (MC_CTRL_TIMEOUT_EN) timeout cases.
module tb_multicycle_control;

  localparam logic [15:0] IREQ = 16'h8000;
  localparam logic [15:0] IRL  = 16'h4000;
  localparam logic [15:0] PCI  = 16'h2000;
  localparam logic [15:0] PCL  = 16'h1000;
  localparam logic [15:0] BSEL = 16'h0080;
  localparam logic [15:0] DREQ = 16'h0040;
  localparam logic [15:0] DWE  = 16'h0020;
  localparam logic [15:0] RW   = 16'h0010;
  localparam logic [15:0] RWD  = 16'h0008;
  localparam logic [15:0] M2R  = 16'h0004;
  localparam logic [15:0] ILL  = 16'h0002;
  localparam logic [15:0] BERR = 16'h0001;
  localparam logic [15:0] FACK = IREQ | IRL | PCI;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic        zero;
    logic        iack;
    logic        dack;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic [7:0]  alu_flags;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req;
  logic        ir_load;
  logic        pc_inc;
  logic        pc_load;
  logic [3:0]  alu_control;
  logic        alu_b_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic        reg_write;
  logic        reg_write_dst;
  logic        mem_to_reg;
  logic        illegal_op;
  logic        bus_err;
  logic [15:0] outVec;

  vec_t vecs[$];
  sb_t  expQ[$];
  int   numCompared = 0;
  int   numMismatched = 0;

  multicycle_control #(.TIMEOUT_CYC(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .alu_flags     (alu_flags),
    .imem_ack      (imem_ack),
    .dmem_ack      (dmem_ack),
    .imem_req      (imem_req),
    .ir_load       (ir_load),
    .pc_inc        (pc_inc),
    .pc_load       (pc_load),
    .alu_control   (alu_control),
    .alu_b_sel     (alu_b_sel),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .reg_write     (reg_write),
    .reg_write_dst (reg_write_dst),
    .mem_to_reg    (mem_to_reg),
    .illegal_op    (illegal_op),
    .bus_err       (bus_err)
  );

  assign outVec = {imem_req, ir_load, pc_inc, pc_load, alu_control, alu_b_sel,
                   dmem_req, dmem_we, reg_write, reg_write_dst, mem_to_reg,
                   illegal_op, bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] alu(input logic [3:0] code);
    return {4'b0000, code, 8'h00};
  endfunction

  task automatic addVec(input string n, input logic [15:0] i, input logic z,
                        input logic ia, input logic da, input logic [15:0] e);
    vec_t v;
    v.name = n; v.instr = i; v.zero = z; v.iack = ia; v.dack = da; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic addAlu(input string n, input logic [3:0] op, input logic [3:0] code);
    logic [15:0] i;
    i = {op, 12'h5A3};
    addVec({n, "-fetch"},  i, 1'b0, 1'b1, 1'b0, FACK);
    addVec({n, "-decode"}, i, 1'b0, 1'b0, 1'b0, 16'h0000);
    addVec({n, "-exec"},   i, 1'b0, 1'b0, 1'b0, alu(code) | BSEL);
    addVec({n, "-wb"},     i, 1'b0, 1'b0, 1'b0, RW);
  endtask

  task automatic addBranch(input string n, input logic [3:0] op, input logic z, input logic take);
    logic [15:0] i;
    i = {op, 12'h123};
    addVec({n, "-fetch"},  i, !z, 1'b1, 1'b0, FACK);
    addVec({n, "-decode"}, i, !z, 1'b0, 1'b0, 16'h0000);
    addVec({n, "-exec"},   i, z,  1'b0, 1'b0, alu(4'b0011) | BSEL | (take ? PCL : 16'h0000));
  endtask

  task automatic applyStimulus(input vec_t v);
    sb_t s;
    instr     = v.instr;
    alu_flags = v.zero ? 8'h02 : 8'hFD;
    imem_ack  = v.iack;
    dmem_ack  = v.dack;
    s.name = v.name;
    s.exp  = v.exp;
    expQ.push_back(s);
  endtask

  task automatic checkOutput();
    sb_t s;
    numCompared++;
    if (expQ.size() == 0) begin
      numMismatched++;
      $display("[TB] FAIL scoreboard: no expected entry, got %h", outVec);
    end else begin
      s = expQ.pop_front();
      if (outVec !== s.exp) begin
        numMismatched++;
        $display("[TB] FAIL %s: got %h required %h", s.name, outVec, s.exp);
      end
    end
  endtask

  task automatic expectNow(input string n, input logic [15:0] e);
    sb_t s;
    s.name = n;
    s.exp  = e;
    expQ.push_back(s);
    checkOutput();
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; instr = 16'h0000; alu_flags = 8'h00; imem_ack = 1'b1; dmem_ack = 1'b1;

    addAlu("add", 4'h4, 4'b0010);
    addAlu("sub", 4'h5, 4'b0011);
    addAlu("and", 4'h6, 4'b0001);
    addAlu("or",  4'h7, 4'b0100);
    addAlu("inv", 4'h8, 4'b0101);
    addAlu("lsl", 4'h9, 4'b0110);
    addAlu("lsr", 4'hA, 4'b0111);
    addAlu("slt", 4'hF, 4'b1000);
    // Acks arriving while nothing is requested must not change the flow
    addVec("spur-fetch",  16'h4111, 1'b0, 1'b1, 1'b1, FACK);
    addVec("spur-decode", 16'h4111, 1'b0, 1'b1, 1'b1, 16'h0000);
    addVec("spur-exec",   16'h4111, 1'b0, 1'b1, 1'b1, alu(4'b0010) | BSEL);
    addVec("spur-wb",     16'h4111, 1'b0, 1'b1, 1'b1, RW);
    // ld with a 2-cycle fetch stall and 3 data wait cycles
    addVec("ld-fstall0", 16'h0000, 1'b0, 1'b0, 1'b0, IREQ);
    addVec("ld-fstall1", 16'h0000, 1'b0, 1'b0, 1'b1, IREQ);
    addVec("ld-fetch",   16'h0000, 1'b0, 1'b1, 1'b0, FACK);
    addVec("ld-decode",  16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000);
    addVec("ld-exec",    16'h1234, 1'b0, 1'b0, 1'b0, alu(4'b0010));
    for (int k = 0; k < 3; k++)
      addVec("ld-memwait", 16'h1234, 1'b0, 1'b1, 1'b0, DREQ | alu(4'b0010));
    addVec("ld-memack",  16'h1234, 1'b0, 1'b0, 1'b1, DREQ | alu(4'b0010));
    addVec("ld-wb",      16'h1234, 1'b0, 1'b0, 1'b0, RW | RWD | M2R);
    addVec("st-fetch",   16'h2345, 1'b0, 1'b1, 1'b0, FACK);
    addVec("st-decode",  16'h2345, 1'b0, 1'b0, 1'b0, 16'h0000);
    addVec("st-exec",    16'h2345, 1'b0, 1'b0, 1'b0, alu(4'b0010));
    addVec("st-memack",  16'h2345, 1'b0, 1'b0, 1'b1, DREQ | DWE | alu(4'b0010));
    addVec("li-fetch",   16'h3456, 1'b0, 1'b1, 1'b0, FACK);
    addVec("li-decode",  16'h3456, 1'b0, 1'b0, 1'b0, 16'h0000);
    addVec("li-exec",    16'h3456, 1'b0, 1'b0, 1'b0, alu(4'b0010));
    addVec("li-wb",      16'h3456, 1'b0, 1'b0, 1'b0, RW | RWD);
    addBranch("beq-z1", 4'hB, 1'b1, 1'b1);
    addBranch("beq-z0", 4'hB, 1'b0, 1'b0);
    addBranch("bne-z0", 4'hC, 1'b0, 1'b1);
    addBranch("bne-z1", 4'hC, 1'b1, 1'b0);
    addVec("jmp-fetch",  16'h0ABC, 1'b0, 1'b1, 1'b0, FACK);
    addVec("jmp-decode", 16'h0ABC, 1'b0, 1'b0, 1'b0, PCL);
    addVec("illE-fetch",  16'hE000, 1'b0, 1'b1, 1'b0, FACK);
    addVec("illE-decode", 16'hE000, 1'b0, 1'b0, 1'b0, ILL);
    addVec("illE-after",  16'hE000, 1'b0, 1'b0, 1'b0, IREQ);
    addVec("illD-fetch",  16'hD000, 1'b0, 1'b1, 1'b0, FACK);
    addVec("illD-decode", 16'hD000, 1'b0, 1'b0, 1'b0, ILL);
`ifdef MC_CTRL_TIMEOUT_EN
    for (int k = 0; k < 4; k++)
      addVec("to-fetchwait", 16'h0000, 1'b0, 1'b0, 1'b0, IREQ);
    addVec("to-fetch-buserr", 16'h0000, 1'b0, 1'b0, 1'b0, BERR);
    addVec("to-ld-fetch",  16'h1000, 1'b0, 1'b1, 1'b0, FACK);
    addVec("to-ld-decode", 16'h1000, 1'b0, 1'b0, 1'b0, 16'h0000);
    addVec("to-ld-exec",   16'h1000, 1'b0, 1'b0, 1'b0, alu(4'b0010));
    for (int k = 0; k < 4; k++)
      addVec("to-ld-memwait", 16'h1000, 1'b0, 1'b0, 1'b0, DREQ | alu(4'b0010));
    addVec("to-mem-buserr", 16'h1000, 1'b0, 1'b0, 1'b0, BERR);
    addVec("to-refetch",    16'h1000, 1'b0, 1'b0, 1'b0, IREQ);
`else
    for (int k = 0; k < 10; k++)
      addVec("nowait-fetch", 16'h0000, 1'b0, 1'b0, 1'b0, IREQ);
    addVec("nowait-jmp-fetch",  16'h0001, 1'b0, 1'b1, 1'b0, FACK);
    addVec("nowait-jmp-decode", 16'h0001, 1'b0, 1'b0, 1'b0, PCL);
`endif

    // Reset holds every output low even with both acks high
    repeat (2) @(posedge clk);
    #1;
    expectNow("reset", 16'h0000);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    rst = 1'b0;

    for (int n = 0; n < vecs.size(); n++)
      runVec(vecs[n]);

    // Asynchronous reset in the middle of a stalled store
    v.instr = 16'h2777; v.zero = 1'b0; v.dack = 1'b0;
    v.name = "rst-st-fetch";  v.iack = 1'b1; v.exp = FACK;                        runVec(v);
    v.name = "rst-st-decode"; v.iack = 1'b0; v.exp = 16'h0000;                    runVec(v);
    v.name = "rst-st-exec";                  v.exp = alu(4'b0010);                runVec(v);
    v.name = "rst-st-mem";                   v.exp = DREQ | DWE | alu(4'b0010);   runVec(v);
    #2;
    rst = 1'b1;
    #1;
    expectNow("rst-mid-mem", 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    v.name = "rst-refetch"; v.exp = IREQ; runVec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
